uoram_flat_backend: RTL and testbench

Cycle-level stand-in for the Path ORAM backend, sitting where the backend sits, on the far side of the frontend data path's store/load streams. It accepts backend commands and sinks the store-data stream for writes. It sources the load-data stream for reads, keeping blocks in a flat on-chip RAM with a per-block valid bit. It gives no obliviousness; it is used for FPGA bring-up and frontend verification with the same chunked, ready/valid protocol as the real backend.

---
 rtl/uoram_flat_backend.sv | 125 ++++++++++++
 tb/tb_uoram_flat_backend.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uoram_flat_backend.sv
// Flat-RAM stand-in for the Path ORAM backend: same chunked ready/valid command,
// store and load streams, blocks kept in one on-chip RAM with a per-block valid bit.
module uoram_flat_backend #(
  parameter int FEDWidth    = 64,
  parameter int BlockChunks = 8,
  parameter int AddrWidth   = 6,
  parameter int BECMDWidth  = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CommandValid,
  output logic                  CommandReady,
  input  logic [BECMDWidth-1:0] Command,
  input  logic [AddrWidth-1:0]  PAddr,
  input  logic                  StoreDataValid,
  output logic                  StoreDataReady,
  input  logic [FEDWidth-1:0]   StoreData,
  output logic                  LoadDataValid,
  input  logic                  LoadDataReady,
  output logic [FEDWidth-1:0]   LoadData
);

  localparam logic [BECMDWidth-1:0] BECMD_Update  = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] BECMD_Append  = BECMDWidth'(1);
  localparam logic [BECMDWidth-1:0] BECMD_Read    = BECMDWidth'(2);
  localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = BECMDWidth'(3);

  localparam int ChunkW = (BlockChunks > 2) ? $clog2(BlockChunks) : 1;
  localparam int Depth  = 1 << (AddrWidth + ChunkW);
  localparam int Blocks = 1 << AddrWidth;
  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(BlockChunks - 1);

  typedef enum logic [1:0] {Idle, Store, LoadFetch, LoadOut} state_t;

  state_t state, nextState;

  logic [AddrWidth-1:0]  addrQ;
  logic [BECMDWidth-1:0] cmdQ;
  logic [ChunkW-1:0]     chunkCtr;
  logic [Blocks-1:0]     blockValid;
  logic                  validQ;
  logic [FEDWidth-1:0]   ramQ;
  logic [FEDWidth-1:0]   ram [Depth];

  logic                  lastChunk;
  logic                  cmdAccept, storeAccept, loadXfer, ramRead;
  logic [AddrWidth+ChunkW-1:0] wordIdx;

  assign lastChunk = (chunkCtr == LastChunk);
  assign wordIdx   = {addrQ, chunkCtr};

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= Idle;
    else       state <= nextState;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      Idle: begin
        if (CommandValid) begin
          case (Command)
            BECMD_Update, BECMD_Append: nextState = Store;
            BECMD_Read, BECMD_ReadRmv:  nextState = LoadFetch;
            default:                    nextState = Store;
          endcase
        end
      end
      Store:     if (StoreDataValid && lastChunk) nextState = Idle;
      LoadFetch: nextState = LoadOut;
      LoadOut:   if (LoadDataReady) nextState = lastChunk ? Idle : LoadFetch;
      default:   nextState = Idle;
    endcase
  end

  // Handshake outputs come from state only, so no valid ever follows a ready.
  always_comb begin
    CommandReady   = (state == Idle);
    StoreDataReady = (state == Store);
    LoadDataValid  = (state == LoadOut);
    ramRead        = (state == LoadFetch);
    cmdAccept      = CommandReady && CommandValid;
    storeAccept    = StoreDataReady && StoreDataValid;
    loadXfer       = LoadDataValid && LoadDataReady;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      addrQ      <= '0;
      cmdQ       <= '0;
      chunkCtr   <= '0;
      blockValid <= '0;
      validQ     <= 1'b0;
    end else begin
      if (cmdAccept) begin
        addrQ    <= PAddr;
        cmdQ     <= Command;
        chunkCtr <= '0;
      end
      if (storeAccept) begin
        if (lastChunk) blockValid[addrQ] <= 1'b1;
        else           chunkCtr <= chunkCtr + ChunkW'(1);
      end
      if (ramRead) validQ <= blockValid[addrQ];
      if (loadXfer) begin
        if (lastChunk) begin
          if (cmdQ == BECMD_ReadRmv) blockValid[addrQ] <= 1'b0;
        end else begin
          chunkCtr <= chunkCtr + ChunkW'(1);
        end
      end
    end
  end

  // RAM is never cleared; the registered valid bit masks stale contents.
  always_ff @(posedge Clock) begin
    if (storeAccept) ram[wordIdx] <= StoreData;
    if (ramRead)     ramQ <= ram[wordIdx];
  end

  assign LoadData = validQ ? ramQ : '0;

endmodule

// File: tb/tb_uoram_flat_backend.sv
// Randomized bench for uoram_flat_backend against a block-level memory model.
module tb_uoram_flat_backend;
  localparam int FW = 64, BC = 8, AW = 6, CW = 2;
  localparam logic [1:0] UPD = 2'd0, APP = 2'd1, RD = 2'd2, RMV = 2'd3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          CommandValid = 1'b0, CommandReady;
  logic [CW-1:0] Command = '0;
  logic [AW-1:0] PAddr = '0;
  logic          StoreDataValid = 1'b0, StoreDataReady;
  logic [FW-1:0] StoreData = '0;
  logic          LoadDataValid, LoadDataReady = 1'b0;
  logic [FW-1:0] LoadData;

  uoram_flat_backend #(.FEDWidth(FW), .BlockChunks(BC), .AddrWidth(AW), .BECMDWidth(CW)) dut (
    .Clock(Clock), .Reset(Reset),
    .CommandValid(CommandValid), .CommandReady(CommandReady), .Command(Command), .PAddr(PAddr),
    .StoreDataValid(StoreDataValid), .StoreDataReady(StoreDataReady), .StoreData(StoreData),
    .LoadDataValid(LoadDataValid), .LoadDataReady(LoadDataReady), .LoadData(LoadData)
  );

  always #5 Clock = ~Clock;

  // Model: block contents and valid bits, plus the expected load stream.
  logic [FW-1:0] mem [64][BC];
  bit   [63:0]   mValid;
  logic [FW-1:0] stData [BC];
  logic [FW-1:0] expQ [$];
  logic [FW-1:0] got [$];
  int nVec = 0, nErr = 0;
  bit holdPending = 0;
  logic [FW-1:0] heldData;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  // Per-cycle compare of the load stream and handshake exclusivity.
  always @(negedge Clock) begin
    if (Reset) holdPending = 0;
    else begin
      if (holdPending) begin
        chk("valid_held", 64'(LoadDataValid), 64'd1);
        if (LoadDataValid) chk("stall_stable", LoadData, heldData);
      end
      holdPending = 0;
      if (LoadDataValid) begin
        if (LoadDataReady) begin
          if (expQ.size() == 0) chk("extra_chunk", 64'(expQ.size()), 64'd1);
          else begin
            logic [FW-1:0] e;
            e = expQ.pop_front();
            chk("load_data", LoadData, e);
            got.push_back(LoadData);
          end
        end else begin
          holdPending = 1;
          heldData = LoadData;
        end
      end
      if (StoreDataReady && LoadDataValid) chk("ready_valid_excl", 64'd1, 64'd0);
    end
  end

  task automatic idleChk(input string nm);
    chk({nm, "_cmdrdy"}, 64'(CommandReady), 64'd1);
    chk({nm, "_strdy"}, 64'(StoreDataReady), 64'd0);
    chk({nm, "_ldvld"}, 64'(LoadDataValid), 64'd0);
  endtask

  task automatic doReset();
    Reset = 1'b1; CommandValid = 0; StoreDataValid = 0;
    tick(); tick();
    Reset = 1'b0;
    idleChk("reset");
    chk("reset_lddata", LoadData, 64'd0);
    mValid = '0;
    expQ.delete();
  endtask

  task automatic doStore(input logic [1:0] cmd, input int addr, input int gapPct, input int resetAfter);
    int cyc, n;
    CommandValid = 1; Command = cmd; PAddr = AW'(addr);
    chk("st_cmd_ready", 64'(CommandReady), 64'd1);
    tick();
    CommandValid = 0; Command = CW'($urandom); PAddr = AW'($urandom);
    cyc = 1; n = 0;
    while (n < BC && cyc < 400) begin
      chk("store_ready", 64'(StoreDataReady), 64'd1);
      chk("store_cmdrdy", 64'(CommandReady), 64'd0);
      StoreDataValid = ($urandom_range(99) >= gapPct);
      StoreData = StoreDataValid ? stData[n] : {$urandom, $urandom};
      tick(); cyc++;
      if (StoreDataValid) n++;
      if (n == resetAfter) begin
        Reset = 1; StoreDataValid = 0;
        tick();
        idleChk("midstore_reset");
        Reset = 0;
        mValid = '0;
        return;
      end
    end
    if (n < BC) chk("store_timeout", 64'(n), 64'(BC));
    // StoreDataValid may still be high here: the extra chunk must not be taken.
    idleChk("store_done");
    StoreDataValid = 0;
    for (int i = 0; i < BC; i++) mem[addr][i] = stData[i];
    mValid[addr] = 1;
  endtask

  task automatic doLoad(input logic [1:0] cmd, input int addr, input int stallPct, input bit holdStore);
    int cyc, xfers, lastXfer;
    bit seen;
    for (int i = 0; i < BC; i++) expQ.push_back(mValid[addr] ? mem[addr][i] : '0);
    got.delete();
    CommandValid = 1; Command = cmd; PAddr = AW'(addr);
    StoreDataValid = holdStore; StoreData = {$urandom, $urandom};
    chk("ld_cmd_ready", 64'(CommandReady), 64'd1);
    tick();
    CommandValid = 0; Command = CW'($urandom); PAddr = AW'($urandom);
    cyc = 1; xfers = 0; lastXfer = 0; seen = 0;
    while (xfers < BC && cyc < 500) begin
      chk("load_cmdrdy", 64'(CommandReady), 64'd0);
      chk("load_strdy", 64'(StoreDataReady), 64'd0);
      LoadDataReady = ($urandom_range(99) >= stallPct);
      if (LoadDataValid) begin
        if (!seen) chk("first_latency", 64'(cyc), 64'd2);
        seen = 1;
        if (LoadDataReady) begin
          if (stallPct == 0 && xfers > 0) chk("load_spacing", 64'(cyc - lastXfer), 64'd2);
          lastXfer = cyc;
          xfers++;
        end
      end
      tick(); cyc++;
    end
    if (xfers < BC) chk("load_timeout", 64'(xfers), 64'(BC));
    idleChk("load_done");
    chk("load_count", 64'(got.size()), 64'(BC));
    chk("exp_drained", 64'(expQ.size()), 64'd0);
    expQ.delete();
    LoadDataReady = 0;
    StoreDataValid = 0;
    if (cmd == RMV) mValid[addr] = 0;
  endtask

  // Hand-computed expectations that do not go through the model.
  task automatic chkLit(input string nm, input logic [63:0] base, input bit incr);
    for (int i = 0; i < BC && i < got.size(); i++)
      chk(nm, got[i], incr ? base + 64'(i) : base);
  endtask

  initial begin
    doReset();

    doLoad(RD, 5, 0, 0);
    chkLit("unwritten_zero", 64'd0, 0);

    for (int i = 0; i < BC; i++) stData[i] = 64'h10 + 64'(i);
    doStore(APP, 3, 0, -1);
    doLoad(RD, 3, 0, 0);
    chkLit("append_read", 64'h10, 1);
    doLoad(RMV, 3, 0, 0);
    chkLit("readrmv", 64'h10, 1);
    doLoad(RD, 3, 0, 0);
    chkLit("after_rmv_zero", 64'd0, 0);

    for (int i = 0; i < BC; i++) stData[i] = {$urandom, $urandom};
    doStore(UPD, 9, 0, -1);
    doLoad(RD, 9, 50, 0);

    for (int i = 0; i < BC; i++) stData[i] = {$urandom, $urandom};
    doStore(UPD, 63, 40, 5);
    doLoad(RD, 63, 0, 0);
    chkLit("reset_midstore_zero", 64'd0, 0);

    for (int i = 0; i < BC; i++) stData[i] = 64'hA0 + 64'(i);
    doStore(UPD, 9, 0, -1);
    doLoad(RD, 9, 0, 1);
    for (int i = 0; i < BC; i++) stData[i] = 64'hB0 + 64'(i);
    StoreDataValid = 1;
    doStore(APP, 12, 0, -1);
    doLoad(RD, 12, 30, 0);
    chkLit("append_after_hold", 64'hB0, 1);

    for (int k = 0; k < 60; k++) begin
      int a;
      logic [1:0] c;
      c = 2'($urandom_range(3));
      a = ($urandom_range(9) == 0) ? 63 : $urandom_range(7);
      if ($urandom_range(29) == 0) doReset();
      else if (c == UPD || c == APP) begin
        for (int i = 0; i < BC; i++) stData[i] = {$urandom, $urandom};
        doStore(c, a, $urandom_range(60), -1);
      end else doLoad(c, a, $urandom_range(60), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
